// File: rtl/ser_capture.sv
// Serial-to-parallel frame capture: start bit (1), WIDTH data bits MSB-first, stop bit (0).
// The parallel word is held with a valid/ready handshake; overrun and framing errors are sticky.
module ser_capture #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             D,
  input  logic             en,
  input  logic             ready,
  output logic [WIDTH-1:0] Q,
  output logic             valid,
  output logic             ovf,
  output logic             ferr
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    STOP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;
  logic               ferr_q, ferr_d;
  logic               frame_done;

  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    q_d        = q_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    ferr_d     = ferr_q;
    frame_done = 1'b0;

    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (D) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          sr_d  = {sr_q[WIDTH-2:0], D};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
        STOP: begin
          state_d = IDLE;
          if (D) begin
            ferr_d = 1'b1;
          end else begin
            frame_done = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A completing frame overrides the plain consume above: a same-edge accept reloads Q.
    if (frame_done) begin
      if (!valid_q || ready) begin
        q_d     = sr_q;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  assign Q     = q_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;
  assign ferr  = ferr_q;

endmodule

// File: tb/tb_ser_capture.sv
// Directed and randomized bench for ser_capture (WIDTH=8) against a frame-level reference model.
module tb_ser_capture;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             D = 1'b0;
  logic             en = 1'b0;
  logic             ready = 1'b0;
  logic [WIDTH-1:0] Q;
  logic             valid;
  logic             ovf;
  logic             ferr;

  int checks = 0;
  int failures = 0;

  ser_capture #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .D     (D),
    .en    (en),
    .ready (ready),
    .Q     (Q),
    .valid (valid),
    .ovf   (ovf),
    .ferr  (ferr)
  );

  always #5 clk = ~clk;

  // Reference model: bits collected since a start bit, plus the held-word handshake.
  logic             m_active = 1'b0;
  logic             m_bits[$];
  logic [WIDTH-1:0] m_q = '0;
  logic             m_valid = 1'b0;
  logic             m_ovf = 1'b0;
  logic             m_ferr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic d, input logic e, input logic r);
    logic             complete;
    logic [WIDTH-1:0] word;
    complete = 1'b0;
    word     = '0;
    if (rst) begin
      m_active = 1'b0;
      m_bits.delete();
      m_q     = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_ferr  = 1'b0;
      return;
    end
    if (e) begin
      if (!m_active) begin
        if (d) begin
          m_active = 1'b1;
          m_bits.delete();
        end
      end else begin
        m_bits.push_back(d);
        if (m_bits.size() == WIDTH + 1) begin
          m_active = 1'b0;
          if (m_bits[WIDTH]) begin
            m_ferr = 1'b1;
          end else begin
            complete = 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
              if (m_bits[i]) word = word | (WIDTH'(1) << (WIDTH - 1 - i));
            end
          end
        end
      end
    end
    if (complete) begin
      if (!m_valid || r) begin
        m_q     = word;
        m_valid = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock: drive inputs, take the edge, then compare all outputs #1 later.
  task automatic step(input logic d, input logic e, input logic r);
    D     = d;
    en    = e;
    ready = r;
    @(posedge clk);
    model_edge(d, e, r);
    #1;
    check("q", 32'(Q), 32'(m_q));
    check("valid", 32'(valid), 32'(m_valid));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("ferr", 32'(ferr), 32'(m_ferr));
  endtask

  // Start bit, data MSB-first, stop bit; gap unsampled cycles before each sampled one.
  task automatic send_frame(input logic [WIDTH-1:0] w, input logic stop_bit,
                            input logic r, input logic stop_r, input int gap);
    logic [WIDTH+1:0] bits;
    bits = {1'b1, w, stop_bit};
    for (int i = WIDTH + 1; i >= 0; i--) begin
      for (int g = 0; g < gap; g++) step(~bits[i], 1'b0, r);
      step(bits[i], 1'b1, (i == 0) ? stop_r : r);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'($urandom), 1'($urandom), 1'($urandom));
    step(1'($urandom), 1'($urandom), 1'($urandom));
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_q", 32'(Q), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);

    // Basic frame, en every cycle, one-cycle valid pulse
    step(1'b0, 1'b1, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 0);
    check("a5_q", 32'(Q), 32'hA5);
    check("a5_valid", 32'(valid), 32'h1);
    step(1'b0, 1'b1, 1'b1);
    check("a5_pulse_end", 32'(valid), 32'h0);

    // Sparse strobe with toggling unsampled D
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 2);
    check("sparse_q", 32'(Q), 32'hA5);
    check("sparse_valid", 32'(valid), 32'h1);
    check("sparse_flags", 32'({ovf, ferr}), 32'h0);
    step(1'b0, 1'b0, 1'b1);
    check("sparse_consume", 32'(valid), 32'h0);

    // Overrun on back-to-back frames with ready low
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 0);
    check("ovr_q", 32'(Q), 32'h3C);
    check("ovr_valid", 32'(valid), 32'h1);
    check("ovr_flag", 32'(ovf), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    check("ovr_hold_q", 32'(Q), 32'h3C);
    step(1'b0, 1'b0, 1'b1);
    check("ovr_consume", 32'(valid), 32'h0);
    check("ovr_sticky", 32'(ovf), 32'h1);

    // Framing error, then a good frame
    do_reset();
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 0);
    check("ferr_flag", 32'(ferr), 32'h1);
    check("ferr_novalid", 32'(valid), 32'h0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 0);
    check("ferr_next_q", 32'(Q), 32'h12);
    check("ferr_next_valid", 32'(valid), 32'h1);
    check("ferr_sticky", 32'(ferr), 32'h1);

    // Reset mid-frame after the 4th data bit
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    check("abort_novalid", 32'(valid), 32'h0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 0);
    check("abort_q", 32'(Q), 32'h81);
    check("abort_valid", 32'(valid), 32'h1);
    check("abort_flags", 32'({ovf, ferr}), 32'h0);

    // Consume on the same edge as the next stop bit
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 0);
    check("same_edge_q", 32'(Q), 32'h5A);
    check("same_edge_valid", 32'(valid), 32'h1);
    check("same_edge_ovf", 32'(ovf), 32'h0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      step(1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
    end
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      send_frame(WIDTH'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom),
                 1'($urandom), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ser_capture.md
SER_CAPTURE -- requirements
Module: ser_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the number of data bits per frame (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port D, input, 1 bit: serial bit stream, driven by the Q of the upstream D flip-flop stage.
REQ-005 SHALL have port en, input, 1 bit: bit strobe; D is sampled only on edges where en=1.
REQ-006 SHALL have port ready, input, 1 bit: consumer accepts the held word when ready=1 and valid=1.
REQ-007 SHALL have port Q, output, WIDTH bits: last accepted parallel word.
REQ-008 SHALL have port valid, output, 1 bit: Q holds an unconsumed word.
REQ-009 SHALL have port ovf, output, 1 bit: sticky overrun flag.
REQ-010 SHALL have port ferr, output, 1 bit: sticky framing-error flag.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT and STOP; en=0 edges change no state, counter or shift register.
REQ-012 IDLE: on a sampled D=1 (start bit), SHALL go to SHIFT with bit counter = 0; a sampled D=0 stays in IDLE.
REQ-013 SHIFT: each sampled bit SHALL shift into the internal shift register MSB-first (first data bit ends up in Q[WIDTH-1]) and increment the counter.
REQ-014 SHIFT SHALL go to STOP on the edge that samples data bit WIDTH-1; the counter is exactly ceil(log2(WIDTH+1)) bits and never wraps.
REQ-015 STOP: a sampled D=0 (valid stop bit) SHALL complete the frame; a sampled D=1 SHALL set ferr, discard the frame, and return to IDLE.
REQ-016 On frame completion, if valid=0, or valid=1 and ready=1 on the same edge, SHALL load Q and set valid=1 on that edge, so the word is visible in the cycle after the stop-bit edge.
REQ-017 On frame completion while valid=1 and ready=0, SHALL keep Q and valid unchanged, drop the new word, and set ovf.
REQ-018 When valid=1 and ready=1 with no completing frame, SHALL clear valid on that edge; Q keeps its last value.
REQ-019 SHALL hold Q and valid stable while valid=1 and ready=0.
REQ-020 SHALL return to IDLE after any STOP sample and be able to accept a new start bit on the very next en edge (back-to-back frames, no gap bit).
REQ-021 ovf and ferr SHALL remain set until rst; they SHALL NOT affect capture of later frames.
REQ-022 ready SHALL be ignored while valid=0.

Reset
REQ-023 With rst=1 at a rising edge, SHALL set the FSM to IDLE, counter = 0, shift register = 0, Q = 0, valid = 0, ovf = 0 and ferr = 0, regardless of en, D or ready.
REQ-024 rst SHALL take priority over all other events, including a reset applied mid-frame; the partial frame is discarded and no valid pulse results.
REQ-025 After rst returns to 0, the first sampled bit SHALL be treated as an IDLE-state sample.

Verification
REQ-026 WIDTH=8, en=1 every cycle, ready=1, D = 1, 1,0,1,0,0,1,0,1, 0 -> Q=8'hA5 and valid=1 for exactly one cycle, one cycle after the stop edge.
REQ-027 Same frame with en=1 only every third cycle and D toggling on the unsampled cycles -> Q=8'hA5; ovf=0, ferr=0.
REQ-028 ready=0, two back-to-back frames 8'h3C then 8'hC3 -> Q stays 8'h3C with valid=1, ovf=1 after the second stop edge; ready=1 for one cycle -> valid=0.
REQ-029 Frame 8'hFF with stop sample D=1 -> ferr=1, valid stays 0; next correct frame 8'h12 -> Q=8'h12, valid=1, ferr still 1.
REQ-030 rst=1 asserted after the 4th data bit of a frame, then a full frame 8'h81 -> no valid from the aborted frame; Q=8'h81 after the new frame; all flags 0.
REQ-031 valid=1 and ready=1 on the same edge as a new frame's stop edge -> old word consumed, Q updates to the new word, valid stays 1, ovf=0.
